bram_stream_reader: RTL
=======================

Name: bram_stream_reader

Overview:
Read-side master for the single-port no-change BRAM (xilinx_single_port_ram_no_change, HIGH_PERFORMANCE mode). On a start command it reads a block of words, beginning at a base address, and presents them on a valid/ready stream. A credit-limited output FIFO absorbs the BRAM read latency, so the stream sustains one word per cycle and tolerates arbitrary backpressure. It sits between a sample buffer written by the capture path and downstream processing.

Parameters:
RAM_WIDTH, 18, data word width (bits)
RAM_DEPTH, 1024, BRAM depth (words); AW = clogb2(RAM_DEPTH-1)
READ_LATENCY, 2, cycles from ram_ena/ram_addr to valid ram_dout (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY)
FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  start pulse, sampled only in IDLE
base_addr  in  AW  first read address, captured on start
length  in  AW+1  word count, captured on start; values > RAM_DEPTH saturate to RAM_DEPTH
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final beat handshakes
ram_ena  out  1  BRAM enable
ram_wea  out  1  tied 0
ram_rsta  out  1  tied 0
ram_regcea  out  1  BRAM output register enable; high while busy
ram_addr  out  AW  BRAM address
ram_dout  in  RAM_WIDTH  BRAM read data
m_data  out  RAM_WIDTH  stream data
m_valid  out  1  stream valid
m_last  out  1  high with the final beat
m_ready  in  1  stream ready

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; busy, done, m_valid, m_last, ram_ena = 0; ram_addr = 0; m_data = 0; FIFO empty; in-flight tags cleared.
- FSM states:
  - IDLE: start=1 with length=0 -> DONE (no reads issued, no beats). start=1 with length>0 -> READ, capturing addr=base_addr and remaining=length.
  - READ: issues reads. Transition to DRAIN when the last read has been issued.
  - DRAIN: waits for in-flight reads to retire and for the FIFO to empty through handshakes. Transition to DONE after the final handshake.
  - DONE: done=1 for one cycle, then IDLE.
- Read issue: a read is issued in a cycle with ram_ena=1 at address A only when (inflight + fifo_count) < FIFO_DEPTH. ram_ena and ram_addr are registered outputs.
  - After each issue: addr increments modulo RAM_DEPTH (wraps RAM_DEPTH-1 -> 0) and remaining decrements.
- Tag pipeline: a READ_LATENCY-stage valid shift register marks each issued read. When a tag exits, ram_dout (= mem[A]) is written into the FIFO. Credit accounting guarantees no FIFO overflow; no data is ever dropped.
- Stream: m_valid = FIFO not empty; m_data = FIFO head. A beat transfers when m_valid && m_ready.
  - m_data/m_valid/m_last stay stable while m_valid && !m_ready.
  - m_last = 1 exactly on the beat with index length-1.
- Timing with defaults:
  - start sampled at edge 0; first ram_ena at cycle 1; first m_valid at cycle 4.
  - With m_ready held 1: one beat per cycle, no bubbles; done at cycle (length+4).
- start while busy: ignored.
- Reset mid-operation: immediate return to IDLE. Outstanding BRAM data is discarded, and no done pulse is produced.
- busy never depends combinationally on m_ready.

Decomposition:
- Package bram_pkg:
  - clogb2 function.
  - Latency constants LAT_HIGH_PERFORMANCE=2, LAT_LOW_LATENCY=1.
  - FSM state encoding (IDLE, READ, DRAIN, DONE).
- Sub-module sync_fifo (params WIDTH, DEPTH; clk/rst_n; wr_en/din, rd_en/dout, count, empty, full). Register-based; dout = head with no read latency.

Test Plan:
- BRAM preloaded mem[i]=i; base=0, length=16, m_ready=1 -> beats 0..15 on cycles 4..19; m_last on 15; done at cycle 20.
- base=1020, length=8 -> data 1020,1021,1022,1023,0,1,2,3 (address wrap); m_last on 3.
- length=10 with m_ready toggling 1,0,0,1 repeating -> all 10 values in order; m_data stable during stalls; inflight+fifo_count never > 4.
- length=0 -> done pulse one cycle after start, no m_valid; length=2000 -> exactly 1024 beats.
- start pulsed again while busy -> ignored, same stream; rst_n low at beat 5 of 16 -> m_valid=0 and busy=0 immediately, no done; next start works from clean state.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM stream reader.
// Width helper, BRAM latency options and FSM encoding.
package bram_pkg;

  localparam int LAT_HIGH_PERFORMANCE = 2;
  localparam int LAT_LOW_LATENCY      = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  function automatic int clogb2(input int value);
    int v;
    clogb2 = 0;
    v = value;
    while (v > 0) begin
      clogb2++;
      v = v >> 1;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO.
// Head word is visible on dout with no read latency.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             wr;
  logic             rd;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;
  assign dout  = mem[rp];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= inc(wp);
      end
      if (rd) begin
        rp <= inc(rp);
      end
      count <= count + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Block reader for a no-change BRAM feeding a valid/ready stream.
// Reads are only issued when a FIFO slot is reserved for the result.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = LAT_HIGH_PERFORMANCE,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_ena,
  output logic                 ram_wea,
  output logic                 ram_rsta,
  output logic                 ram_regcea,
  output logic [AW-1:0]        ram_addr,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                  state;
  logic [AW-1:0]           addr;
  logic [AW:0]             remaining;
  logic [AW:0]             out_left;
  logic [AW:0]             len_sat;
  logic [READ_LATENCY-1:0] tag;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_wr;
  logic                    pop;
  logic                    issue;
  logic [7:0]              pending;

  assign ram_wea    = 1'b0;
  assign ram_rsta   = 1'b0;
  assign ram_regcea = busy;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (out_left == (AW+1)'(1));
  assign fifo_wr = tag[READ_LATENCY-1] && !fifo_full;

  // Clamp the requested block to one full pass of the BRAM.
  always_comb begin
    len_sat = length;
    if (length > (AW+1)'(RAM_DEPTH)) begin
      len_sat = (AW+1)'(RAM_DEPTH);
    end
  end

  // Words owed to the FIFO; a beat leaving this cycle frees a slot.
  always_comb begin
    pending = 8'(ram_ena) + 8'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      pending = pending + 8'(tag[i]);
    end
    issue = (state == READ) &&
            ((pending - 8'(pop)) < 8'(FIFO_DEPTH));
  end

  // Control FSM, read issue and tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_ena   <= 1'b0;
      ram_addr  <= '0;
      addr      <= '0;
      remaining <= '0;
      out_left  <= '0;
      tag       <= '0;
    end else begin
      done    <= 1'b0;
      ram_ena <= issue;
      tag[0]  <= ram_ena;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
      if (issue) begin
        ram_addr  <= addr;
        remaining <= remaining - 1'b1;
        if (addr == AW'(RAM_DEPTH - 1)) begin
          addr <= '0;
        end else begin
          addr <= addr + 1'b1;
        end
      end
      if (pop) begin
        out_left <= out_left - 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= READ;
              busy      <= 1'b1;
              addr      <= base_addr;
              remaining <= len_sat;
              out_left  <= len_sat;
            end
          end
        end
        READ: begin
          if (issue && remaining == (AW+1)'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_left == (AW+1)'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   (ram_dout),
    .rd_en (pop),
    .dout  (m_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
